// File: rtl/music_pkg.sv
// Shared melody/tone-generator definitions: FSM encodings, song entry layout,
// special note codes and the note-name constants used by the tone generator.
package music_pkg;

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_FETCH = 3'd1;
  localparam logic [ST_W-1:0] ST_LOAD  = 3'd2;
  localparam logic [ST_W-1:0] ST_PLAY  = 3'd3;
  localparam logic [ST_W-1:0] ST_GAP   = 3'd4;

  localparam int unsigned ENTRY_W   = 12;
  localparam int unsigned NOTE_W    = 4;
  localparam int unsigned OCT_W     = 3;
  localparam int unsigned DUR_W     = 5;
  localparam int unsigned DUR_CNT_W = 6;
  localparam int unsigned NOTE_LSB  = 8;
  localparam int unsigned OCT_LSB   = 5;
  localparam int unsigned DUR_LSB   = 0;

  localparam logic [NOTE_W-1:0] NOTE_REST_MIN = 4'd12;
  localparam logic [NOTE_W-1:0] NOTE_END      = 4'd15;
  localparam logic [OCT_W-1:0]  OCTAVE_MAX    = 3'd5;

  localparam logic [NOTE_W-1:0] NOTE_A  = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_AS = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_B  = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_C  = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_CS = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_D  = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_DS = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_E  = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_F  = 4'd8;
  localparam logic [NOTE_W-1:0] NOTE_FS = 4'd9;
  localparam logic [NOTE_W-1:0] NOTE_G  = 4'd10;
  localparam logic [NOTE_W-1:0] NOTE_GS = 4'd11;

  // A zero duration field encodes the longest note, 32 ticks.
  function automatic logic [DUR_CNT_W-1:0] dur_ticks(input logic [DUR_W-1:0] d);
    return (d == '0) ? 6'd32 : {1'b0, d};
  endfunction

  function automatic logic [OCT_W-1:0] clamp_octave(input logic [OCT_W-1:0] o);
    return (o > OCTAVE_MAX) ? OCTAVE_MAX : o;
  endfunction

endpackage

// File: rtl/melody_sequencer_tempo_tick.sv
// Tempo prescaler: one-cycle tick every TICK_DIV enabled cycles, synchronous clear.
module tempo_tick #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_c = en && (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick_c ? '0 : CNT_W'(cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/melody_sequencer.sv
// Steps a synchronous song ROM and drives tone-generator note/octave selects.
// Define NOTE_GAP_EN to insert a one-tick silent gap after every entry.
module melody_sequencer
  import music_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 16000000,
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              STOP,
  input  logic              LOOP,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic [11:0]       ROM_DATA,
  output logic [3:0]        NOTE,
  output logic [2:0]        OCTAVE,
  output logic              NOTE_EN,
  output logic              BUSY,
  output logic              DONE
);

  if (TICK_DIV < 2 || CLK_HZ < TICK_DIV) begin : g_bad_params
    $error("melody_sequencer: TICK_DIV must be >= 2 and <= CLK_HZ");
  end

  logic [ST_W-1:0]      state_q, state_d;
  logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
  logic [NOTE_W-1:0]    note_q, note_d;
  logic [OCT_W-1:0]     octave_q, octave_d;
  logic                 note_en_q, note_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DUR_CNT_W-1:0] dur_q, dur_d;
  logic                 tick_clr_c, tick_en_c, tick_c, advance_c;

  logic [NOTE_W-1:0] rom_note_c;
  logic [OCT_W-1:0]  rom_oct_c;
  logic [DUR_W-1:0]  rom_dur_c;

  assign rom_note_c = ROM_DATA[NOTE_LSB +: NOTE_W];
  assign rom_oct_c  = ROM_DATA[OCT_LSB  +: OCT_W];
  assign rom_dur_c  = ROM_DATA[DUR_LSB  +: DUR_W];

  tempo_tick #(.TICK_DIV(TICK_DIV)) u_tempo_tick (
    .clk    (CLK),
    .rst    (RESET),
    .clr    (tick_clr_c),
    .en     (tick_en_c),
    .tick_c (tick_c)
  );

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    note_d     = note_q;
    octave_d   = octave_q;
    note_en_d  = note_en_q;
    done_d     = 1'b0;
    dur_d      = dur_q;
    tick_clr_c = 1'b0;
    tick_en_c  = 1'b0;
    advance_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START && !STOP) begin
          rom_addr_d = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        if (rom_note_c == NOTE_END) begin
          if (LOOP) begin
            rom_addr_d = '0;
            state_d    = ST_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          // Rests leave NOTE/OCTAVE at the last tone; only NOTE_EN is gated.
          if (rom_note_c < NOTE_REST_MIN) begin
            note_d    = rom_note_c;
            octave_d  = clamp_octave(rom_oct_c);
            note_en_d = 1'b1;
          end else begin
            note_en_d = 1'b0;
          end
          dur_d      = dur_ticks(rom_dur_c);
          tick_clr_c = 1'b1;
          state_d    = ST_PLAY;
        end
      end
      ST_PLAY: begin
        tick_en_c = 1'b1;
        if (tick_c) begin
          if (dur_q == DUR_CNT_W'(1)) begin
            note_en_d = 1'b0;
`ifdef NOTE_GAP_EN
            state_d   = ST_GAP;
`else
            advance_c = 1'b1;
`endif
          end else begin
            dur_d = DUR_CNT_W'(dur_q - 1'b1);
          end
        end
      end
`ifdef NOTE_GAP_EN
      ST_GAP: begin
        tick_en_c = 1'b1;
        if (tick_c) advance_c = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (advance_c) begin
      if (rom_addr_q != {ADDR_W{1'b1}}) begin
        rom_addr_d = ADDR_W'(rom_addr_q + 1'b1);
        state_d    = ST_FETCH;
      end else if (LOOP) begin
        rom_addr_d = '0;
        state_d    = ST_FETCH;
      end else begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end

    // STOP overrides every other transition once playback is underway.
    if (STOP && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      note_en_d = 1'b0;
      done_d    = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      note_q     <= '0;
      octave_q   <= '0;
      note_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dur_q      <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      note_q     <= note_d;
      octave_q   <= octave_d;
      note_en_q  <= note_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dur_q      <= dur_d;
    end
  end

  assign ROM_ADDR = rom_addr_q;
  assign NOTE     = note_q;
  assign OCTAVE   = octave_q;
  assign NOTE_EN  = note_en_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer (TICK_DIV=4, ADDR_W=3).
module tb_melody_sequencer;

`ifdef NOTE_GAP_EN
  localparam int GAP_C = 4;
`else
  localparam int GAP_C = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [2:0]  rom_addr;
  logic [11:0] rom_data = 12'h000;
  logic [3:0]  note;
  logic [2:0]  octave;
  logic        note_en;
  logic        busy;
  logic        done;

  logic [11:0] rom [8];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  melody_sequencer #(.TICK_DIV(4), .ADDR_W(3)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .START    (start),
    .STOP     (stop),
    .LOOP     (loop_en),
    .ROM_ADDR (rom_addr),
    .ROM_DATA (rom_data),
    .NOTE     (note),
    .OCTAVE   (octave),
    .NOTE_EN  (note_en),
    .BUSY     (busy),
    .DONE     (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom(input logic [11:0] v);
    for (int i = 0; i < 8; i++) rom[i] = v;
  endtask

  // After return the bench sits in the first cycle after START was sampled.
  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (note_en === 1'b1 && n < 300) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    total_cnt++;
    if ({rom_addr, note, octave, note_en, busy, done} !== 13'd0) begin
      $display("FAIL reset_values: got %h required 0", {rom_addr, note, octave, note_en, busy, done});
    end else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_tone();
    int n;
    int k;
    fill_rom(12'hF00);
    rom[0] = 12'h0A2;
    start_pulse();
    total_cnt++;
    if (busy !== 1'b1 || note_en !== 1'b0) begin
      $display("FAIL basic_busy: busy=%b note_en=%b required 1/0", busy, note_en);
    end else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (note_en !== 1'b1 || note !== 4'd0 || octave !== 3'd5) begin
      $display("FAIL basic_first: en=%b note=%0d oct=%0d required 1/0/5", note_en, note, octave);
    end else pass_cnt++;
    count_high(n);
    total_cnt++;
    if (n !== 8) begin
      $display("FAIL basic_len: got %0d required 8", n);
    end else pass_cnt++;
    k = 0;
    while (done !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    total_cnt++;
    if (k !== 2 + GAP_C || busy !== 1'b0) begin
      $display("FAIL basic_done: delay=%0d busy=%b required %0d/0", k, busy, 2 + GAP_C);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL basic_done_pulse: done=%b busy=%b required 0/0", done, busy);
    end else pass_cnt++;
  endtask

  task automatic test_rest();
    int n;
    int m;
    logic changed;
    fill_rom(12'hF00);
    rom[0] = 12'h0A1;
    rom[1] = 12'hC01;
    rom[2] = 12'h3A1;
    start_pulse();
    step();
    step();
    count_high(n);
    total_cnt++;
    if (n !== 4) begin
      $display("FAIL rest_first_len: got %0d required 4", n);
    end else pass_cnt++;
    m = 0;
    changed = 1'b0;
    while (note_en !== 1'b1 && m < 100) begin
      if (note !== 4'd0) changed = 1'b1;
      step();
      m++;
    end
    total_cnt++;
    if (m !== 8 + 2 * GAP_C || changed !== 1'b0) begin
      $display("FAIL rest_silence: len=%0d changed=%b required %0d/0", m, changed, 8 + 2 * GAP_C);
    end else pass_cnt++;
    total_cnt++;
    if (note !== 4'd3 || octave !== 3'd5) begin
      $display("FAIL rest_second: note=%0d oct=%0d required 3/5", note, octave);
    end else pass_cnt++;
    m = 0;
    while (busy === 1'b1 && m < 100) begin
      step();
      m++;
    end
  endtask

  task automatic test_loop();
    int k;
    logic seen_done;
    logic seen_en;
    fill_rom(12'h0A1);
    loop_en = 1'b1;
    start_pulse();
    k = 0;
    while (rom_addr !== 3'd7 && k < 200) begin
      step();
      k++;
    end
    seen_done = 1'b0;
    k = 0;
    while (rom_addr === 3'd7 && k < 50) begin
      if (done === 1'b1) seen_done = 1'b1;
      step();
      k++;
    end
    total_cnt++;
    if (rom_addr !== 3'd0 || seen_done !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL loop_wrap: addr=%0d done_seen=%b busy=%b required 0/0/1", rom_addr, seen_done, busy);
    end else pass_cnt++;
    seen_en = 1'b0;
    k = 0;
    while (!seen_en && k < 20) begin
      step();
      if (note_en === 1'b1) seen_en = 1'b1;
      k++;
    end
    total_cnt++;
    if (seen_en !== 1'b1) begin
      $display("FAIL loop_continue: note_en_seen=%b required 1", seen_en);
    end else pass_cnt++;
    loop_en = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    total_cnt++;
    if (done !== 1'b1 || rom_addr !== 3'd7 || busy !== 1'b0) begin
      $display("FAIL loop_end: done=%b addr=%0d busy=%b required 1/7/0", done, rom_addr, busy);
    end else pass_cnt++;
    step();
  endtask

  task automatic test_stop();
    fill_rom(12'hF00);
    rom[0] = 12'h55F;
    start_pulse();
    repeat (22) step();
    total_cnt++;
    if (note_en !== 1'b1 || note !== 4'd5 || octave !== 3'd2) begin
      $display("FAIL stop_playing: en=%b note=%0d oct=%0d required 1/5/2", note_en, note, octave);
    end else pass_cnt++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    total_cnt++;
    if (note_en !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL stop_abort: en=%b done=%b busy=%b required 0/1/0", note_en, done, busy);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (done !== 1'b0 || note !== 4'd5) begin
      $display("FAIL stop_after: done=%b note=%0d required 0/5", done, note);
    end else pass_cnt++;
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL start_stop_same: busy=%b done=%b required 0/0", busy, done);
    end else pass_cnt++;
    repeat (3) step();
    total_cnt++;
    if (busy !== 1'b0 || note_en !== 1'b0 || done !== 1'b0) begin
      $display("FAIL start_stop_idle: busy=%b en=%b done=%b required 0/0/0", busy, note_en, done);
    end else pass_cnt++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL stop_in_idle: done=%b busy=%b required 0/0", done, busy);
    end else pass_cnt++;
  endtask

  task automatic test_async_reset();
    fill_rom(12'hF00);
    rom[0] = 12'h0A1;
    rom[1] = 12'h55F;
    start_pulse();
    repeat (14) step();
    total_cnt++;
    if (note_en !== 1'b1 || note !== 4'd5 || rom_addr !== 3'd1) begin
      $display("FAIL rst_pre: en=%b note=%0d addr=%0d required 1/5/1", note_en, note, rom_addr);
    end else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({rom_addr, note, octave, note_en, busy, done} !== 13'd0) begin
      $display("FAIL rst_async: got %h required 0", {rom_addr, note, octave, note_en, busy, done});
    end else pass_cnt++;
    step();
    rst = 1'b0;
    step();
    start_pulse();
    step();
    step();
    total_cnt++;
    if (note_en !== 1'b1 || note !== 4'd0 || octave !== 3'd5) begin
      $display("FAIL rst_restart: en=%b note=%0d oct=%0d required 1/0/5", note_en, note, octave);
    end else pass_cnt++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  task automatic test_dur0_octave();
    int n;
    int k;
    fill_rom(12'hF00);
    rom[0] = 12'h3E0;
    start_pulse();
    step();
    step();
    total_cnt++;
    if (note !== 4'd3 || octave !== 3'd5 || note_en !== 1'b1) begin
      $display("FAIL oct_clamp: note=%0d oct=%0d en=%b required 3/5/1", note, octave, note_en);
    end else pass_cnt++;
    count_high(n);
    total_cnt++;
    if (n !== 128) begin
      $display("FAIL dur0_len: got %0d required 128", n);
    end else pass_cnt++;
    k = 0;
    while (done !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    total_cnt++;
    if (k !== 2 + GAP_C) begin
      $display("FAIL dur0_done: delay=%0d required %0d", k, 2 + GAP_C);
    end else pass_cnt++;
    step();
  endtask

  initial begin
    fill_rom(12'hF00);
    test_reset();
    test_basic_tone();
    test_rest();
    test_loop();
    test_stop();
    test_async_reset();
    test_dur0_octave();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a stored melody through the tone generator by stepping a song ROM and driving the generator's note and octave selects for timed durations. It sits upstream of the speaker tone generator and replaces its free-running note counter with a tempo-driven, start/stop-controlled schedule. The song ROM is external, synchronous, with one-cycle read latency.

## Interface
- `CLK_HZ`, 16000000: system clock frequency; documentation only.
- `TICK_DIV`, 1000000: CLK cycles per tempo tick; 16 ticks/s at 16 MHz; ≥2.
- `ADDR_W`, 5: song ROM address width; song length is 2^ADDR_W entries.
- `CLK`  in  1  system clock; all state on the rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `START`  in  1  one-cycle pulse; starts playback from address 0 when idle.
- `STOP`  in  1  one-cycle pulse; aborts playback and returns to idle.
- `LOOP`  in  1  level; when high, the end of the song wraps to address 0.
- `ROM_ADDR`  out  ADDR_W  song ROM read address, registered.
- `ROM_DATA`  in  12  entry from the ROM: [11:8] note, [7:5] octave, [4:0] duration.
- `NOTE`  out  4  note select to the tone generator, 0..11 (A..G#).
- `OCTAVE`  out  3  octave select to the tone generator, 0..5.
- `NOTE_EN`  out  1  high while the tone generator should sound.
- `BUSY`  out  1  high in every state except IDLE.
- `DONE`  out  1  one-cycle pulse when the song ends without looping, or when STOP aborts.

## Operation
- Entry decode:
  - note 0..11 is a tone.
  - note 12..14 is a rest: NOTE_EN=0 for the duration.
  - note 15 is the end marker; its duration field is ignored.
  - Duration is in ticks, 1..31. A duration of 0 means 32 ticks.
  - An octave field above 5 is clamped to 5.
- FSM states: IDLE, FETCH, LOAD, PLAY, GAP.
  - IDLE, on START: ROM_ADDR←0, go to FETCH.
  - FETCH: wait one cycle for ROM latency.
  - LOAD: sample ROM_DATA.
    - End marker with LOOP=1: ROM_ADDR←0, go to FETCH.
    - End marker with LOOP=0: pulse DONE, go to IDLE.
    - Otherwise: latch NOTE/OCTAVE, load the duration counter, clear the tick prescaler, and go to PLAY.
  - PLAY: the prescaler counts TICK_DIV cycles per tick. When the last tick expires, go to GAP if NOTE_GAP_EN is defined, otherwise advance.
  - GAP: NOTE_EN=0 for one tick, then advance.
  - Advance:
    - If ROM_ADDR is not 2^ADDR_W−1: ROM_ADDR←ROM_ADDR+1, go to FETCH.
    - At the last address with LOOP=1: wrap to 0, go to FETCH.
    - At the last address with LOOP=0: pulse DONE, go to IDLE.
- STOP in any non-IDLE state: go to IDLE next cycle, NOTE_EN←0, pulse DONE.
- STOP and START in the same cycle: STOP wins. In IDLE, no DONE pulse.
- START while BUSY: ignored.
- STOP in IDLE: ignored, no DONE.
- NOTE and OCTAVE hold their last played value in IDLE, GAP and rests. Only NOTE_EN gates sound.

## Timing
- Reset values: ROM_ADDR=0, NOTE=0, OCTAVE=0, NOTE_EN=0, BUSY=0, DONE=0, state IDLE, counters 0.
- RESET mid-note forces the reset values immediately, asynchronously.
- START at cycle t:
  - BUSY=1 at t+1.
  - ROM_DATA sampled at t+2.
  - NOTE_EN=1 at t+3 for a tone.
- A tone of duration d holds NOTE_EN=1 for exactly d·TICK_DIV cycles.
- Entry-to-entry overhead is 2 cycles (FETCH and LOAD), with NOTE_EN=0 during them.
- With NOTE_GAP_EN defined, add TICK_DIV more cycles of silence.
- DONE is high for exactly one cycle, coincident with BUSY falling.

## Configuration
- `NOTE_GAP_EN` defined: a one-tick silent GAP follows every tone and rest, so repeated identical notes are audibly separated.
- `NOTE_GAP_EN` not defined: the GAP state is absent. Consecutive entries are separated only by the 2-cycle fetch overhead.

## Structure
- Shared package `music_pkg`:
  - FSM state enum.
  - Entry field bit positions.
  - Note codes `NOTE_REST_MIN`=12 and `NOTE_END`=15.
  - `OCTAVE_MAX`=5.
  - The note-name constants shared with the tone generator.
- One sub-module `tempo_tick`: TICK_DIV prescaler with a synchronous clear and a one-cycle tick pulse. The FSM and duration counter stay in the top.

## Test plan
Bench parameters: TICK_DIV=4, ADDR_W=3.
- ROM {0x0A2, 0xF00}, START pulse:
  - NOTE=0, OCTAVE=5, NOTE_EN=1 for exactly 8 cycles starting 3 cycles after START.
  - Then DONE for one cycle, BUSY=0.
- Rest entry 0xC01 between two tones: NOTE_EN=0 for 4 cycles plus overhead. NOTE is unchanged across the rest.
- LOOP=1, ROM with no end marker and 8 entries of duration 1:
  - ROM_ADDR goes 7→0 without a DONE pulse, and playback continues.
  - Deassert LOOP: DONE after address 7.
- STOP midway through a 31-tick note: NOTE_EN=0 and DONE=1 the next cycle. START and STOP in the same cycle from IDLE: no activity.
- RESET asserted mid-PLAY: all outputs at reset values without a clock edge, and START works normally afterwards.
- Duration 0 entry: NOTE_EN=1 for 128 cycles. Octave field 7: OCTAVE=5. With NOTE_GAP_EN defined: 4 silent cycles added per entry.
